// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one unified instruction/data memory between the
// CPU datapath (port C) and the debug/loader port (port D). One transaction
// at a time, round-robin arbitration with a bounded debug burst-hold, all
// outputs registered. Sequence per transaction: IDLE -> ISSUE -> WAIT -> ACK.
module mem_port_arbiter #(
    parameter int AW       = 8,
    parameter int MEM_LAT  = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [31:0]   c_wdata,
    output logic [31:0]   c_rdata,
    output logic          c_ack,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    input  logic          d_hold,
    output logic [31:0]   d_rdata,
    output logic          d_ack,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,

    output logic [1:0]    owner
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_ACK   = 2'd3;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_C    = 2'b01;
    localparam logic [1:0] OWN_D    = 2'b10;

    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);
    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    logic [1:0]    state_q,     state_d;
    logic [2:0]    wait_cnt_q,  wait_cnt_d;
    logic [3:0]    hold_cnt_q,  hold_cnt_d;
    logic          last_d_q,    last_d_d;     // 1 = D was the last port served
    logic [1:0]    owner_q,     owner_d;
    logic          txn_we_q,    txn_we_d;     // direction of the transaction in flight
    logic          mem_en_q,    mem_en_d;
    logic          mem_we_q,    mem_we_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [31:0]   c_rdata_q,   c_rdata_d;
    logic [31:0]   d_rdata_q,   d_rdata_d;
    logic          c_ack_q,     c_ack_d;
    logic          d_ack_q,     d_ack_d;

    logic          d_hold_wins;
    logic          grant_c;
    logic          grant_d;

    // Arbitration: round-robin on a tie, unless D holds ownership for a burst
    // and has not yet used up its hold budget.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the
        // block leaves a value unassigned and no latch is inferred.
        grant_c     = 1'b0;
        grant_d     = 1'b0;
        d_hold_wins = last_d_q && d_hold && (hold_cnt_q < HOLD_MAX);
        if (c_req && d_req) begin
            if (last_d_q && !d_hold_wins) begin
                grant_c = 1'b1;
            end else begin
                grant_d = 1'b1;
            end
        end else if (c_req) begin
            grant_c = 1'b1;
        end else if (d_req) begin
            grant_d = 1'b1;
        end
    end

    // Next-state logic for the transaction sequencer and all registered outputs.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        last_d_d    = last_d_q;
        owner_d     = owner_q;
        txn_we_d    = txn_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        c_rdata_d   = c_rdata_q;
        d_rdata_d   = d_rdata_q;
        // Strobes are high for a single cycle, so they default low.
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        c_ack_d     = 1'b0;
        d_ack_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_c) begin
                    owner_d     = OWN_C;
                    txn_we_d    = c_we;
                    mem_we_d    = c_we;
                    mem_addr_d  = c_addr;
                    mem_wdata_d = c_wdata;
                    mem_en_d    = 1'b1;
                    hold_cnt_d  = 4'd0;
                    state_d     = ST_ISSUE;
                end else if (grant_d) begin
                    owner_d     = OWN_D;
                    txn_we_d    = d_we;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_en_d    = 1'b1;
                    state_d     = ST_ISSUE;
                end
                // A D grant that keeps C waiting consumes hold budget; that
                // takes precedence over the clear on a non-holding IDLE cycle.
                if (grant_d && c_req) begin
                    if (hold_cnt_q < HOLD_MAX) begin
                        hold_cnt_d = hold_cnt_q + 4'd1;
                    end
                end else if (!grant_c && !d_hold) begin
                    hold_cnt_d = 4'd0;
                end else if (grant_c) begin
                    hold_cnt_d = 4'd0;
                end
            end

            ST_ISSUE: begin
                wait_cnt_d = LAT_INIT;
                state_d    = ST_WAIT;
            end

            ST_WAIT: begin
                if (wait_cnt_q <= 3'd1) begin
                    wait_cnt_d = 3'd0;
                    if (!txn_we_q) begin
                        if (owner_q == OWN_C) begin
                            c_rdata_d = mem_rdata;
                        end else begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                    c_ack_d = (owner_q == OWN_C);
                    d_ack_d = (owner_q == OWN_D);
                    state_d = ST_ACK;
                end else begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end
            end

            default: begin // ST_ACK
                last_d_d = (owner_q == OWN_D);
                owner_d  = OWN_NONE;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= 3'd0;
            hold_cnt_q  <= 4'd0;
            last_d_q    <= 1'b1;   // C wins the first tie after reset
            owner_q     <= OWN_NONE;
            txn_we_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            c_rdata_q   <= 32'd0;
            d_rdata_q   <= 32'd0;
            c_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            last_d_q    <= last_d_d;
            owner_q     <= owner_d;
            txn_we_q    <= txn_we_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            c_rdata_q   <= c_rdata_d;
            d_rdata_q   <= d_rdata_d;
            c_ack_q     <= c_ack_d;
            d_ack_q     <= d_ack_d;
        end
    end

    assign c_rdata   = c_rdata_q;
    assign c_ack     = c_ack_q;
    assign d_rdata   = d_rdata_q;
    assign d_ack     = d_ack_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a cycle-by-cycle vector table
// for the basic read/write/tie cases on a MEM_LAT=1 instance, plus
// hand-written sequences for burst-hold, MEM_LAT=3 and mid-transaction reset.
module tb_mem_port_arbiter;

    localparam int NV = 25;

    logic        clk;
    logic        rst;
    logic        c_req, c_req3, c_we, d_req, d_we, d_hold;
    logic [7:0]  c_addr, d_addr;
    logic [31:0] c_wdata, d_wdata;

    // MEM_LAT = 1 instance
    logic [31:0] c_rdata, d_rdata, mem_wdata, mem_rdata;
    logic        c_ack, d_ack, mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [1:0]  owner;

    // MEM_LAT = 3 instance
    logic [31:0] c_rdata3, d_rdata3, mem_wdata3, mem_rdata3;
    logic        c_ack3, d_ack3, mem_en3, mem_we3;
    logic [7:0]  mem_addr3;
    logic [1:0]  owner3;

    // Memory preload port (writes both memory models)
    logic        pl_we;
    logic [7:0]  pl_addr;
    logic [31:0] pl_data;

    int n_cmp;
    int n_bad;

    mem_port_arbiter #(.AW(8), .MEM_LAT(1), .MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_ack(c_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_hold(d_hold), .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner)
    );

    mem_port_arbiter #(.AW(8), .MEM_LAT(3), .MAX_HOLD(4)) dut3 (
        .clk(clk), .rst(rst),
        .c_req(c_req3), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata3), .c_ack(c_ack3),
        .d_req(1'b0), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_hold(d_hold), .d_rdata(d_rdata3), .d_ack(d_ack3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
        .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .owner(owner3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: read data is valid only in the cycle MEM_LAT after mem_en,
    // garbage otherwise, so a mistimed capture is visible.
    logic [31:0] m1 [256];
    logic [31:0] m3 [256];
    logic        p1_v;
    logic [31:0] p1_d;
    logic [2:0]  p3_v;
    logic [31:0] p3_d [3];

    always @(posedge clk) begin
        if (pl_we) begin
            m1[pl_addr] <= pl_data;
            m3[pl_addr] <= pl_data;
        end else begin
            if (mem_en && mem_we)   m1[mem_addr]  <= mem_wdata;
            if (mem_en3 && mem_we3) m3[mem_addr3] <= mem_wdata3;
        end
        p1_v    <= mem_en && !mem_we;
        p1_d    <= m1[mem_addr];
        p3_v    <= {p3_v[1:0], mem_en3 && !mem_we3};
        p3_d[0] <= m3[mem_addr3];
        p3_d[1] <= p3_d[0];
        p3_d[2] <= p3_d[1];
    end

    assign mem_rdata  = p1_v    ? p1_d    : 32'hBAD0_BAD0;
    assign mem_rdata3 = p3_v[2] ? p3_d[2] : 32'hBAD0_BAD0;

    typedef struct {
        logic        rst;
        logic        c_req;
        logic        c_we;
        logic [7:0]  c_addr;
        logic [31:0] c_wdata;
        logic        d_req;
        logic        d_we;
        logic [7:0]  d_addr;
        logic [31:0] d_wdata;
        logic        d_hold;
        logic        e_en;
        logic        e_we;
        logic [7:0]  e_addr;
        logic [1:0]  e_own;
        logic        e_cack;
        logic        e_dack;
        logic [31:0] e_crd;
        logic [31:0] e_drd;
    } vec_t;

    vec_t tv [NV];

    function automatic vec_t v(
        input logic r, input logic cr, input logic cw, input logic [7:0] ca, input logic [31:0] cd,
        input logic dr, input logic dw, input logic [7:0] da, input logic [31:0] dd, input logic dh,
        input logic en, input logic we, input logic [7:0] ad, input logic [1:0] ow,
        input logic ck, input logic dk, input logic [31:0] crd, input logic [31:0] drd);
        vec_t t;
        t.rst = r;   t.c_req = cr; t.c_we = cw; t.c_addr = ca; t.c_wdata = cd;
        t.d_req = dr; t.d_we = dw; t.d_addr = da; t.d_wdata = dd; t.d_hold = dh;
        t.e_en = en; t.e_we = we; t.e_addr = ad; t.e_own = ow;
        t.e_cack = ck; t.e_dack = dk; t.e_crd = crd; t.e_drd = drd;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pl_we   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(posedge clk);
        #1;
        pl_we   = 1'b0;
    endtask

    task automatic apply(input vec_t t);
        rst     = t.rst;
        c_req   = t.c_req;
        c_we    = t.c_we;
        c_addr  = t.c_addr;
        c_wdata = t.c_wdata;
        d_req   = t.d_req;
        d_we    = t.d_we;
        d_addr  = t.d_addr;
        d_wdata = t.d_wdata;
        d_hold  = t.d_hold;
    endtask

    // Waits (bounded) for the next ack on the MEM_LAT=1 instance: 1 = C, 2 = D, 0 = none.
    task automatic wait_ack(output int who);
        who = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (c_ack) begin
                who = 1;
                break;
            end
            if (d_ack) begin
                who = 2;
                break;
            end
        end
    endtask

    initial begin
        int who;
        int k;
        int exp_seq [6];

        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1; c_req = 1'b0; c_req3 = 1'b0; c_we = 1'b0; c_addr = 8'h00; c_wdata = 32'd0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 8'h00; d_wdata = 32'd0; d_hold = 1'b0;
        pl_we = 1'b0; pl_addr = 8'h00; pl_data = 32'd0;

        preload(8'h04, 32'hDEADBEEF);
        preload(8'h20, 32'hA5A50001);
        preload(8'h30, 32'h5A5A0002);
        preload(8'h44, 32'hCAFEF00D);
        preload(8'h45, 32'h0BADBEEF);

        // One row per cycle: inputs held during the cycle, outputs expected in it.
        //            rst cr cw caddr  cwdata         dr dw daddr  dwdata         dh  en we addr  own   ck dk c_rdata        d_rdata
        // C read of 0x04 straight out of reset
        tv[0]  = v(1, 1, 0, 8'h04, 32'h0,         0, 0, 8'h00, 32'h0,         0,  0, 0, 8'h00, 2'b00, 0, 0, 32'h0,         32'h0);
        tv[1]  = v(0, 1, 0, 8'h04, 32'h0,         0, 0, 8'h00, 32'h0,         0,  0, 0, 8'h00, 2'b00, 0, 0, 32'h0,         32'h0);
        tv[2]  = v(0, 1, 0, 8'h04, 32'h0,         0, 0, 8'h00, 32'h0,         0,  1, 0, 8'h04, 2'b01, 0, 0, 32'h0,         32'h0);
        tv[3]  = v(0, 1, 0, 8'h04, 32'h0,         0, 0, 8'h00, 32'h0,         0,  0, 0, 8'h00, 2'b01, 0, 0, 32'h0,         32'h0);
        tv[4]  = v(0, 0, 0, 8'h04, 32'h0,         0, 0, 8'h00, 32'h0,         0,  0, 0, 8'h00, 2'b01, 1, 0, 32'hDEADBEEF,  32'h0);
        tv[5]  = v(0, 0, 0, 8'h04, 32'h0,         0, 0, 8'h00, 32'h0,         0,  0, 0, 8'h00, 2'b00, 0, 0, 32'hDEADBEEF,  32'h0);
        // Simultaneous C and D after reset: C first, D four cycles later
        tv[6]  = v(1, 1, 0, 8'h20, 32'h0,         1, 0, 8'h30, 32'h0,         0,  0, 0, 8'h00, 2'b00, 0, 0, 32'h0,         32'h0);
        tv[7]  = v(0, 1, 0, 8'h20, 32'h0,         1, 0, 8'h30, 32'h0,         0,  0, 0, 8'h00, 2'b00, 0, 0, 32'h0,         32'h0);
        tv[8]  = v(0, 1, 0, 8'h20, 32'h0,         1, 0, 8'h30, 32'h0,         0,  1, 0, 8'h20, 2'b01, 0, 0, 32'h0,         32'h0);
        tv[9]  = v(0, 1, 0, 8'h20, 32'h0,         1, 0, 8'h30, 32'h0,         0,  0, 0, 8'h00, 2'b01, 0, 0, 32'h0,         32'h0);
        tv[10] = v(0, 0, 0, 8'h20, 32'h0,         1, 0, 8'h30, 32'h0,         0,  0, 0, 8'h00, 2'b01, 1, 0, 32'hA5A50001,  32'h0);
        tv[11] = v(0, 0, 0, 8'h20, 32'h0,         1, 0, 8'h30, 32'h0,         0,  0, 0, 8'h00, 2'b00, 0, 0, 32'hA5A50001,  32'h0);
        tv[12] = v(0, 0, 0, 8'h20, 32'h0,         1, 0, 8'h30, 32'h0,         0,  1, 0, 8'h30, 2'b10, 0, 0, 32'hA5A50001,  32'h0);
        tv[13] = v(0, 0, 0, 8'h20, 32'h0,         1, 0, 8'h30, 32'h0,         0,  0, 0, 8'h00, 2'b10, 0, 0, 32'hA5A50001,  32'h0);
        tv[14] = v(0, 0, 0, 8'h20, 32'h0,         0, 0, 8'h30, 32'h0,         0,  0, 0, 8'h00, 2'b10, 0, 1, 32'hA5A50001,  32'h5A5A0002);
        tv[15] = v(0, 0, 0, 8'h20, 32'h0,         0, 0, 8'h30, 32'h0,         0,  0, 0, 8'h00, 2'b00, 0, 0, 32'hA5A50001,  32'h5A5A0002);
        // D writes 0x10 (inputs changed after the grant), then C reads it back
        tv[16] = v(0, 0, 0, 8'h00, 32'h0,         1, 1, 8'h10, 32'h12345678,  0,  0, 0, 8'h00, 2'b00, 0, 0, 32'hA5A50001,  32'h5A5A0002);
        tv[17] = v(0, 0, 0, 8'h00, 32'h0,         1, 1, 8'h10, 32'hFFFFFFFF,  0,  1, 1, 8'h10, 2'b10, 0, 0, 32'hA5A50001,  32'h5A5A0002);
        tv[18] = v(0, 0, 0, 8'h00, 32'h0,         1, 0, 8'h20, 32'hFFFFFFFF,  0,  0, 0, 8'h00, 2'b10, 0, 0, 32'hA5A50001,  32'h5A5A0002);
        tv[19] = v(0, 0, 0, 8'h00, 32'h0,         0, 0, 8'h20, 32'h0,         0,  0, 0, 8'h00, 2'b10, 0, 1, 32'hA5A50001,  32'h5A5A0002);
        tv[20] = v(0, 1, 0, 8'h10, 32'h0,         0, 0, 8'h00, 32'h0,         0,  0, 0, 8'h00, 2'b00, 0, 0, 32'hA5A50001,  32'h5A5A0002);
        tv[21] = v(0, 1, 0, 8'h10, 32'h0,         0, 0, 8'h00, 32'h0,         0,  1, 0, 8'h10, 2'b01, 0, 0, 32'hA5A50001,  32'h5A5A0002);
        tv[22] = v(0, 1, 0, 8'h10, 32'h0,         0, 0, 8'h00, 32'h0,         0,  0, 0, 8'h00, 2'b01, 0, 0, 32'hA5A50001,  32'h5A5A0002);
        tv[23] = v(0, 0, 0, 8'h10, 32'h0,         0, 0, 8'h00, 32'h0,         0,  0, 0, 8'h00, 2'b01, 1, 0, 32'h12345678,  32'h5A5A0002);
        tv[24] = v(0, 0, 0, 8'h10, 32'h0,         0, 0, 8'h00, 32'h0,         0,  0, 0, 8'h00, 2'b00, 0, 0, 32'h12345678,  32'h5A5A0002);

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            apply(tv[i]);
            @(negedge clk);
            check($sformatf("row%0d ctl{en,we,own,cack,dack}", i),
                  {mem_en, mem_we, owner, c_ack, d_ack},
                  {tv[i].e_en, tv[i].e_we, tv[i].e_own, tv[i].e_cack, tv[i].e_dack});
            if (tv[i].e_en) check($sformatf("row%0d mem_addr", i), mem_addr, tv[i].e_addr);
            check($sformatf("row%0d c_rdata", i), c_rdata, tv[i].e_crd);
            check($sformatf("row%0d d_rdata", i), d_rdata, tv[i].e_drd);
        end

        // Burst hold: C first (no hold yet), then four D grants, then C again.
        exp_seq = '{1, 2, 2, 2, 2, 1};
        rst = 1'b1;
        c_req = 1'b1; c_we = 1'b0; c_addr = 8'h20;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h30; d_hold = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        d_hold = 1'b1;
        for (int g = 0; g < 6; g++) begin
            wait_ack(who);
            check($sformatf("hold grant %0d (1=C 2=D)", g), who, exp_seq[g]);
        end
        c_req = 1'b0; d_req = 1'b0; d_hold = 1'b0;

        // MEM_LAT=3 single C read; address change during WAIT must be ignored.
        rst = 1'b1;
        c_req3 = 1'b1; c_we = 1'b0; c_addr = 8'h44;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("lat3 issue {en,we,own}", {mem_en3, mem_we3, owner3}, {1'b1, 1'b0, 2'b01});
        check("lat3 issue mem_addr", mem_addr3, 8'h44);
        c_addr = 8'h45;
        @(negedge clk);
        check("lat3 wait mem_addr held", mem_addr3, 8'h44);
        @(negedge clk);
        @(negedge clk);
        check("lat3 no early ack", c_ack3, 1'b0);
        @(negedge clk);
        check("lat3 ack in cycle 5", c_ack3, 1'b1);
        check("lat3 c_rdata", c_rdata3, 32'hCAFEF00D);
        c_req3 = 1'b0;
        @(negedge clk);
        check("lat3 ack one cycle", {c_ack3, d_ack3, owner3}, 4'b0000);
        check("lat3 d_rdata untouched", d_rdata3, 32'h0);

        // Reset during WAIT of a D read, then a fresh transaction on release.
        rst = 1'b1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h30;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst-seq issue {en,own}", {mem_en, owner}, {1'b1, 2'b10});
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst in WAIT {en,dack,own}", {mem_en, d_ack, owner}, 4'b0000);
        @(negedge clk);
        check("rst held no ack", {d_ack, d_rdata}, 33'd0);
        rst = 1'b0;
        k = 1;
        while (k <= 10) begin
            @(negedge clk);
            if (d_ack) break;
            k++;
        end
        check("rst recover ack latency", k, 3);
        check("rst recover d_rdata", d_rdata, 32'h5A5A0002);
        d_req = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory between two requesters: the multi-cycle CPU datapath (port C: instruction fetch and load/store) and the debug/loader port (port D: program download and memory inspection).
- Serialises accesses, issues one memory transaction at a time, returns read data and a one-cycle ack to the winner.
- Uses round-robin arbitration with a bounded debug burst-hold.
- Sits between the CPU controller/datapath, the debug unit and the memory macro.

Parameters:
- AW, 8, memory word-address width.
- MEM_LAT, 1, memory read latency in cycles, from the cycle mem_en is high to the cycle mem_rdata is valid; legal range 1..4.
- MAX_HOLD, 4, maximum consecutive D grants under d_hold while C is requesting; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- c_req  in  1  CPU request; held high until c_ack.
- c_we  in  1  CPU write enable; 1 = write.
- c_addr  in  AW  CPU word address.
- c_wdata  in  32  CPU write data.
- c_rdata  out  32  CPU read data; valid in the c_ack cycle and held until the next C read completes.
- c_ack  out  1  one-cycle completion strobe to the CPU.
- d_req  in  1  debug request; held high until d_ack.
- d_we  in  1  debug write enable.
- d_addr  in  AW  debug word address.
- d_wdata  in  32  debug write data.
- d_hold  in  1  debug asks to keep ownership for its next transaction (burst).
- d_rdata  out  32  debug read data; same holding rule as c_rdata.
- d_ack  out  1  one-cycle completion strobe to the debug port.
- mem_en  out  1  memory access strobe; high for exactly one cycle per transaction.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  AW  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data.
- owner  out  2  current owner, for the LED display: 00 = none, 01 = C, 10 = D.

Behaviour:
- Reset (asynchronous, rst=1):
  - State returns to IDLE.
  - mem_en, mem_we, c_ack and d_ack go to 0; owner goes to 00.
  - mem_addr, mem_wdata, c_rdata and d_rdata go to 0.
  - last_owner = D, so C wins the first tie.
  - Hold counter = 0.
  - A transaction in flight is abandoned with no ack. Requests still high after reset release are re-arbitrated as new requests.
- All outputs are registered.
- State machine: IDLE -> ISSUE -> WAIT -> ACK -> IDLE.
  - IDLE:
    - Neither request high: stay in IDLE, owner = 00.
    - Exactly one request high: grant that port.
    - Both high: grant the port not equal to last_owner. Override: if last_owner = D, d_hold = 1 and hold_cnt < MAX_HOLD, grant D.
    - On grant: latch we, addr and wdata from the winner, set owner, go to ISSUE.
  - ISSUE:
    - mem_en = 1 for this cycle, with mem_we/mem_addr/mem_wdata from the latched values.
    - Load the wait counter with MEM_LAT and go to WAIT.
  - WAIT:
    - Decrement the counter each cycle.
    - In the cycle it reaches 0 (MEM_LAT cycles after ISSUE), capture mem_rdata into the owner's rdata register (reads only; writes leave rdata unchanged) and go to ACK.
  - ACK:
    - Owner's ack = 1 for exactly this cycle.
    - Update last_owner = owner; set owner to 00 on the IDLE transition; go to IDLE.
- Latency: a request sampled high in IDLE at cycle 0 gets mem_en in cycle 1 and ack in cycle MEM_LAT+2. Occupancy is MEM_LAT+3 cycles per transaction.
- Request rules:
  - Inputs other than req are sampled only at the grant.
  - Changing addr/we/wdata after the grant has no effect.
  - A req still high in the cycle after ack is a new request.
- hold_cnt:
  - Increments on each D grant made while c_req = 1.
  - Clears on any C grant, or on an IDLE cycle with d_hold = 0.
  - Saturates at MAX_HOLD. At MAX_HOLD with c_req high, C is granted next regardless of d_hold.
- Simultaneous events:
  - A new req arriving while busy waits; no queueing beyond the req level.
  - Deasserting req before ack is a protocol violation. The transaction completes and is acked anyway.
- Address width: AW bits, passed through unchanged. No wrap or translation.

Test Plan:
1. Reset with c_req=1, c_we=0, c_addr=8'h04, memory[4]=32'hDEADBEEF, MEM_LAT=1 -> mem_en high in cycle 1 with mem_addr=04, c_ack high in cycle 3, c_rdata=DEADBEEF, owner=01 during cycles 1-3.
2. c_req and d_req rise in the same cycle after reset -> C is served first, then D. mem_en strobes are 4 cycles apart; d_ack arrives 4 cycles after c_ack.
3. D writes 32'h12345678 to 8'h10, then C reads 8'h10 -> mem_we=1 exactly one cycle, d_ack with d_rdata unchanged, then c_rdata=12345678.
4. d_hold=1, d_req and c_req continuously high, MAX_HOLD=4 -> grant sequence D(after C's first),D,D,D,C; hold_cnt saturates at 4 and C is granted on the 5th arbitration.
5. MEM_LAT=3, single C read -> ack in cycle 5, with mem_rdata captured in the cycle 3 after mem_en. Check that a mid-WAIT change of c_addr is ignored.
6. Assert rst during WAIT of a D read -> mem_en/d_ack/owner are 0 immediately. After release with d_req still high, a fresh transaction is acked MEM_LAT+2 cycles later.
